seq_serializer: RTL and testbench

//  - Parallel-to-serial stage directly upstream of the 1011 sequence detector; its dout drives the detector's din.
//  - Accepts WIDTH-bit words on a valid/ready handshake and shifts them out MSB-first, one bit per clk.
//  - Back-to-back words stream with no idle gap.
//  - Marks valid bit slots and pulses word_done on the final bit of each word.

---
 rtl/seq_serializer.sv | 118 +++++++++++
 tb/tb_seq_serializer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for the 1011 detector: MSB-first, 1 clk accept->first bit, gapless streaming.
// Optional even-parity trailer bit when SEQ_SER_PARITY_EN is defined; s_ready low while a word is in flight.
module seq_serializer #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             dout,
  output logic             dout_vld,
  output logic             busy,
  output logic             word_done
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SEQ_SER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             dout_nxt, vld_nxt, done_nxt;
  logic             accept;
`ifdef SEQ_SER_PARITY_EN
  logic             par_q, par_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      dout      <= IDLE_BIT;
      dout_vld  <= 1'b0;
      word_done <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      shreg     <= shreg_nxt;
      dout      <= dout_nxt;
      dout_vld  <= vld_nxt;
      word_done <= done_nxt;
`ifdef SEQ_SER_PARITY_EN
      par_q     <= par_nxt;
`endif
    end
  end

  always_comb begin
    s_ready   = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    dout_nxt  = IDLE_BIT;
    vld_nxt   = 1'b0;
    done_nxt  = 1'b0;
`ifdef SEQ_SER_PARITY_EN
    par_nxt   = par_q;
`endif

    case (state)
      IDLE: s_ready = 1'b1;
      SHIFT: begin
        dout_nxt  = shreg[WIDTH-1];
        vld_nxt   = 1'b1;
        shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
        cnt_nxt   = cnt + 1'b1;
        if (cnt == LAST) begin
          cnt_nxt = '0;
`ifdef SEQ_SER_PARITY_EN
          state_nxt = PAR;
`else
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          s_ready   = 1'b1;
`endif
        end
      end
`ifdef SEQ_SER_PARITY_EN
      PAR: begin
        dout_nxt  = par_q;
        vld_nxt   = 1'b1;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
        s_ready   = 1'b1;
      end
`endif
      default: state_nxt = IDLE;
    endcase

    if (rst) s_ready = 1'b0;
    accept = s_valid && s_ready;

    // Every ready state loads the new word the same way, which keeps back-to-back words gapless.
    if (accept) begin
      state_nxt = SHIFT;
      cnt_nxt   = '0;
      shreg_nxt = s_data;
`ifdef SEQ_SER_PARITY_EN
      par_nxt   = ^s_data;
`endif
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: queue-based bit-slot model checked every cycle, plus directed literal checks.
module tb_seq_serializer;
  localparam int   WIDTH    = 8;
  localparam logic IDLE_BIT = 1'b0;
`ifdef SEQ_SER_PARITY_EN
  localparam int PARB = 1;
`else
  localparam int PARB = 0;
`endif
  localparam int SLOTS = WIDTH + PARB;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] s_data = '0;
  logic             s_valid = 1'b0;
  logic             s_ready, dout, dout_vld, busy, word_done;

  seq_serializer #(.WIDTH(WIDTH), .IDLE_BIT(IDLE_BIT)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .dout(dout), .dout_vld(dout_vld), .busy(busy), .word_done(word_done)
  );

  always #5 clk = ~clk;

  int vec  = 0;
  int errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of pending bit slots {last, bit}; one slot leaves per clock.
  logic [1:0] q[$];
  logic m_dout = IDLE_BIT, m_vld = 1'b0, m_done = 1'b0, m_acc = 1'b0, started = 1'b0;

  always @(posedge clk) begin
    logic [1:0] e;
    logic       lst;
    started = 1'b1;
    m_acc   = 1'b0;
    if (rst) begin
      q.delete();
      m_dout = IDLE_BIT; m_vld = 1'b0; m_done = 1'b0;
    end else begin
      m_acc = s_valid && (q.size() <= 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        m_dout = e[0]; m_done = e[1]; m_vld = 1'b1;
      end else begin
        m_dout = IDLE_BIT; m_vld = 1'b0; m_done = 1'b0;
      end
      if (m_acc) begin
        for (int k = 0; k < WIDTH; k++) begin
          lst = (PARB == 0) && (k == WIDTH - 1);
          q.push_back({lst, s_data[WIDTH-1-k]});
        end
        if (PARB != 0) q.push_back({1'b1, ^s_data});
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("dout",      dout,      m_dout);
      chk("dout_vld",  dout_vld,  m_vld);
      chk("word_done", word_done, m_done);
      chk("busy",      busy,      q.size() > 0);
      chk("s_ready",   s_ready,   !rst && (q.size() <= 1));
    end
  end

  logic cap_b[$], cap_v[$], cap_d[$];

  task automatic step();
    @(posedge clk); #2;
    cap_b.push_back(dout); cap_v.push_back(dout_vld); cap_d.push_back(word_done);
  endtask

  task automatic clear_cap();
    cap_b.delete(); cap_v.delete(); cap_d.delete();
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    int n;
    n = 0;
    s_data = w; s_valid = 1'b1;
    do begin step(); n++; end while (!m_acc && n < 64);
    chk("accept_wait", m_acc, 1'b1);
    s_valid = 1'b0; s_data = ~w;
  endtask

  logic [SLOTS-1:0]   e1;
  logic [2*SLOTS-1:0] e2;
  logic [WIDTH-1:0]   wrd;
  logic               pending;

  initial begin
`ifdef SEQ_SER_PARITY_EN
    e1 = {8'hB0, 1'b1};
    e2 = {8'hB0, 1'b1, 8'h0B, 1'b1};
`else
    e1 = 8'hB0;
    e2 = {8'hB0, 8'h0B};
`endif
    // Reset held for two clocks
    rst = 1'b1;
    step(); step();
    chk("rst_dout", dout, 1'b0);
    chk("rst_vld", dout_vld, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", s_ready, 1'b0);
    rst = 1'b0; #1;
    chk("post_rst_ready", s_ready, 1'b1);

    // Single word 8'hB0
    clear_cap();
    push(8'hB0);
    repeat (SLOTS + 1) step();
    for (int i = 1; i <= SLOTS; i++) begin
      chk("single_bit", cap_b[i], e1[SLOTS-i]);
      chk("single_vld", cap_v[i], 1'b1);
      chk("single_done", cap_d[i], i == SLOTS);
    end
    chk("single_idle_vld", cap_v[SLOTS+1], 1'b0);

    // Back-to-back 8'hB0, 8'h0B
    clear_cap();
    push(8'hB0);
    push(8'h0B);
    chk("b2b_accept_edge", cap_b.size(), SLOTS + 1);
    repeat (SLOTS + 1) step();
    for (int i = 1; i <= 2 * SLOTS; i++) begin
      chk("b2b_bit", cap_b[i], e2[2*SLOTS-i]);
      chk("b2b_vld", cap_v[i], 1'b1);
      chk("b2b_done", cap_d[i], (i == SLOTS) || (i == 2 * SLOTS));
    end
    chk("b2b_idle_vld", cap_v[2*SLOTS+1], 1'b0);

    // Backpressure: 8'hFF offered while busy, taken only on the last slot
    clear_cap();
    push(8'hB0);
    push(8'hFF);
    chk("bp_accept_edge", cap_b.size(), SLOTS + 1);
    repeat (WIDTH) step();
    for (int i = SLOTS + 1; i <= SLOTS + WIDTH; i++) chk("bp_bit", cap_b[i], 1'b1);
    repeat (4) step();

    // Reset mid-word
    clear_cap();
    push(8'hB0);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0; #1;
    chk("midrst_dout", dout, 1'b0);
    chk("midrst_vld", dout_vld, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", s_ready, 1'b1);
    repeat (12) step();
    for (int i = 4; i < cap_b.size(); i++) begin
      chk("midrst_no_vld", cap_v[i], 1'b0);
      chk("midrst_no_done", cap_d[i], 1'b0);
    end

    // Randomized traffic with occasional resets; a pending word is held until taken
    pending = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!pending) begin
        if ($urandom_range(0, 3) != 0) begin
          wrd = WIDTH'($urandom);
          s_data = wrd; s_valid = 1'b1; pending = 1'b1;
        end else begin
          s_valid = 1'b0; s_data = WIDTH'($urandom);
        end
      end
      rst = ($urandom_range(0, 199) == 0);
      step();
      if (m_acc) pending = 1'b0;
    end
    rst = 1'b0; s_valid = 1'b0;
    repeat (2 * SLOTS + 4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
